// File: rtl/elevator_call_scheduler_pkg.sv
// elevator_call_scheduler_pkg: shared floor width, default floor count, FSM states and sweep helper
package elevator_call_scheduler_pkg;
  localparam int FLOOR_W = 4;
  localparam int NUM_FLOORS_DEF = 10;
  typedef enum logic [1:0] {ST_IDLE, ST_SERVE_UP, ST_SERVE_DOWN, ST_DOOR} state_t;
  function automatic state_t sweep_next(input logic dir, input logic up, input logic dn);
    return (up && (dir || !dn)) ? ST_SERVE_UP : dn ? ST_SERVE_DOWN : ST_IDLE;
  endfunction
endpackage

// File: rtl/elevator_call_scheduler_call_priority_search.sv
// call_priority_search: nearest pending floor above/below the car
module call_priority_search
  import elevator_call_scheduler_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  above_any,
  output logic                  below_any,
  output logic [FLOOR_W-1:0]    near_above,
  output logic [FLOOR_W-1:0]    near_below
);
  // scan downward so the lowest floor above wins, upward so the highest floor below wins
  always_comb begin
    above_any = 1'b0;
    below_any = 1'b0;
    near_above = current_floor;
    near_below = current_floor;
    for (int i = NUM_FLOORS - 1; i >= 0; i--)
      if (pending[i] && i > int'(current_floor)) begin
        above_any = 1'b1;
        near_above = FLOOR_W'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending[i] && i < int'(current_floor)) begin
        below_any = 1'b1;
        near_below = FLOOR_W'(i);
      end
  end
endmodule

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: SCAN call scheduler with pending bitmap and door dwell timer
module elevator_call_scheduler
  import elevator_call_scheduler_pkg::*;
#(
  parameter int          NUM_FLOORS   = NUM_FLOORS_DEF,
  parameter logic [31:0] DWELL_CYCLES = 32'd50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  call_valid,
  input  logic [FLOOR_W-1:0]    call_floor,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  car_idle,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic                  door_open,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  call_err,
  output logic                  busy
);
  localparam logic [4:0] NF = 5'(NUM_FLOORS);
  state_t state, state_n;
  logic [FLOOR_W-1:0] target_n, near_above, near_below;
  logic above_any, below_any, here, dir_n, door_n, call_ok;
  logic [NUM_FLOORS-1:0] here_mask, set_mask, clr_mask, pending_n;
  logic [31:0] dwell_cnt, cnt_n;

  call_priority_search #(.NUM_FLOORS(NUM_FLOORS)) u_search (
    .pending      (pending),
    .current_floor(current_floor),
    .above_any    (above_any),
    .below_any    (below_any),
    .near_above   (near_above),
    .near_below   (near_below)
  );

  assign here_mask = NUM_FLOORS'(1) << current_floor;
  assign here = |(pending & here_mask);
  assign call_ok = call_valid && ({1'b0, call_floor} < NF);
  assign set_mask = (call_ok && !(state == ST_DOOR && call_floor == current_floor)) ? NUM_FLOORS'(1) << call_floor : '0;
  assign clr_mask = (state_n == ST_DOOR && state != ST_DOOR) ? here_mask : '0;
  assign pending_n = (pending | set_mask) & ~clr_mask;
  assign busy = state != ST_IDLE;

  // next state, dwell timing, sweep direction and target selection
  always_comb begin
    state_n = state;
    door_n = door_open;
    cnt_n = dwell_cnt;
    case (state)
      ST_IDLE: state_n = (here && car_idle) ? ST_DOOR : sweep_next(dir_up, above_any, below_any);
      ST_SERVE_UP: state_n = (here && car_idle) ? ST_DOOR : (!above_any && !here) ? ST_IDLE : ST_SERVE_UP;
      ST_SERVE_DOWN: state_n = (here && car_idle) ? ST_DOOR : (!below_any && !here) ? ST_IDLE : ST_SERVE_DOWN;
      default: begin
        cnt_n = dwell_cnt + 32'd1;
        if (dwell_cnt == DWELL_CYCLES - 32'd1) begin
          state_n = sweep_next(dir_up, above_any, below_any);
          door_n = 1'b0;
          cnt_n = '0;
        end
      end
    endcase
    if (state_n == ST_DOOR && state != ST_DOOR) begin
      door_n = 1'b1;
      cnt_n = '0;
    end
    dir_n = (state_n == ST_SERVE_UP) ? 1'b1 : (state_n == ST_SERVE_DOWN) ? 1'b0 : dir_up;
    target_n = (state_n == ST_SERVE_UP) ? near_above : (state_n == ST_SERVE_DOWN) ? near_below : current_floor;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_IDLE;
    else state <= state_n;

  // pending bitmap, dwell counter and registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pending <= '0;
      target_floor <= '0;
      door_open <= 1'b0;
      dir_up <= 1'b1;
      dwell_cnt <= '0;
      call_err <= 1'b0;
    end else begin
      pending <= pending_n;
      target_floor <= target_n;
      door_open <= door_n;
      dir_up <= dir_n;
      dwell_cnt <= cnt_n;
      call_err <= call_valid && !call_ok;
    end
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// tb_elevator_call_scheduler: directed stimulus checked against a behavioural scheduler model
module tb_elevator_call_scheduler;
  localparam int NF = 10;
  localparam int DW = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic call_valid = 1'b0;
  logic [3:0] call_floor = '0;
  logic [3:0] current_floor = '0;
  logic car_idle = 1'b1;
  logic [3:0] target_floor;
  logic door_open, dir_up, call_err, busy;
  logic [NF-1:0] pending;
  int n_pass = 0;
  int n_total = 0;

  elevator_call_scheduler #(.NUM_FLOORS(NF), .DWELL_CYCLES(32'd4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .call_valid   (call_valid),
    .call_floor   (call_floor),
    .current_floor(current_floor),
    .car_idle     (car_idle),
    .target_floor (target_floor),
    .door_open    (door_open),
    .dir_up       (dir_up),
    .pending      (pending),
    .call_err     (call_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef enum {M_IDLE, M_UP, M_DOWN, M_DOOR} mode_t;
  bit mp[16];
  mode_t mm, nm;
  int mtarget, mleft, cf, na, nb;
  bit mdoor, mdir, merr, here, ua, da;

  function automatic int pend_mask();
    int m = 0;
    for (int f = 0; f < NF; f++) if (mp[f]) m |= 1 << f;
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int f = 0; f < 16; f++) mp[f] = 1'b0;
      mm = M_IDLE;
      mtarget = 0;
      mdoor = 1'b0;
      mdir = 1'b1;
      merr = 1'b0;
      mleft = 0;
    end else begin
      cf = int'(current_floor);
      here = cf < NF && mp[cf];
      na = -1;
      nb = -1;
      for (int f = 0; f < NF; f++) begin
        if (mp[f] && f > cf && na < 0) na = f;
        if (mp[f] && f < cf) nb = f;
      end
      ua = na >= 0;
      da = nb >= 0;
      nm = mm;
      if (mm == M_DOOR) begin
        mleft--;
        if (mleft == 0) begin
          mdoor = 1'b0;
          if (mdir) nm = ua ? M_UP : da ? M_DOWN : M_IDLE;
          else nm = da ? M_DOWN : ua ? M_UP : M_IDLE;
        end
      end else if (here && car_idle) nm = M_DOOR;
      else if (mm == M_IDLE) begin
        if (ua && da) nm = mdir ? M_UP : M_DOWN;
        else if (ua) nm = M_UP;
        else if (da) nm = M_DOWN;
      end else if (mm == M_UP && !ua && !here) nm = M_IDLE;
      else if (mm == M_DOWN && !da && !here) nm = M_IDLE;
      if (nm == M_UP) mdir = 1'b1;
      if (nm == M_DOWN) mdir = 1'b0;
      merr = call_valid && int'(call_floor) >= NF;
      if (call_valid && !merr && !(mm == M_DOOR && int'(call_floor) == cf)) mp[call_floor] = 1'b1;
      if (nm == M_DOOR && mm != M_DOOR) begin
        mp[cf] = 1'b0;
        mdoor = 1'b1;
        mleft = DW;
      end
      mtarget = (nm == M_UP && ua) ? na : (nm == M_DOWN && da) ? nb : cf;
      mm = nm;
    end
  end

  always @(negedge clk) begin
    chk("target_floor", int'(target_floor), mtarget);
    chk("door_open", int'(door_open), int'(mdoor));
    chk("dir_up", int'(dir_up), int'(mdir));
    chk("pending", int'(pending), pend_mask());
    chk("call_err", int'(call_err), int'(merr));
    chk("busy", int'(busy), int'(mm != M_IDLE));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic call(input int f);
    call_valid = 1'b1;
    call_floor = 4'(f);
    tick();
    call_valid = 1'b0;
  endtask

  task automatic dwell_rest();
    repeat (3) begin
      tick();
      chk("door_held", int'(door_open), 1);
    end
    tick();
    chk("door_closed", int'(door_open), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_target", int'(target_floor), 0);
    chk("rst_dir", int'(dir_up), 1);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    call(3);
    chk("t1_pending", int'(pending), 'h008);
    tick();
    chk("t1_target", int'(target_floor), 3);
    chk("t1_busy", int'(busy), 1);
    current_floor = 4'd3;
    tick();
    chk("t1_door", int'(door_open), 1);
    chk("t1_cleared", int'(pending), 0);
    dwell_rest();
    chk("t1_idle", int'(busy), 0);
    chk("t1_target_end", int'(target_floor), 3);
    current_floor = 4'd0;
    tick();
    call(7);
    tick();
    chk("t2_target7", int'(target_floor), 7);
    car_idle = 1'b0;
    current_floor = 4'd1;
    call(4);
    chk("t2_pending", int'(pending), 'h090);
    chk("t2_not_yet", int'(target_floor), 7);
    tick();
    chk("t2_retarget", int'(target_floor), 4);
    current_floor = 4'd4;
    tick();
    chk("t2_moving_no_door", int'(door_open), 0);
    car_idle = 1'b1;
    tick();
    chk("t2_door", int'(door_open), 1);
    chk("t2_pending_after", int'(pending), 'h080);
    dwell_rest();
    chk("t2_resume", int'(target_floor), 7);
    chk("t2_dir", int'(dir_up), 1);
    current_floor = 4'd7;
    tick();
    dwell_rest();
    current_floor = 4'd5;
    call(5);
    tick();
    chk("t3_door5", int'(door_open), 1);
    call(2);
    call(8);
    chk("t3_pending", int'(pending), 'h104);
    tick();
    tick();
    chk("t3_first8", int'(target_floor), 8);
    chk("t3_dir_up", int'(dir_up), 1);
    current_floor = 4'd8;
    tick();
    dwell_rest();
    chk("t3_then2", int'(target_floor), 2);
    chk("t3_dir_down", int'(dir_up), 0);
    current_floor = 4'd2;
    tick();
    dwell_rest();
    call(12);
    chk("t4_err", int'(call_err), 1);
    chk("t4_pending", int'(pending), 0);
    tick();
    chk("t4_err_drop", int'(call_err), 0);
    call(10);
    chk("t4_err10", int'(call_err), 1);
    call(9);
    chk("t4_ok9", int'(call_err), 0);
    chk("t4_pending9", int'(pending), 'h200);
    tick();
    current_floor = 4'd9;
    tick();
    dwell_rest();
    current_floor = 4'd4;
    call(4);
    tick();
    chk("t5_door", int'(door_open), 1);
    call(4);
    chk("t5_absorbed", int'(pending), 0);
    call(6);
    chk("t5_pending6", int'(pending), 'h040);
    tick();
    chk("t5_still_open", int'(door_open), 1);
    tick();
    chk("t5_no_restart", int'(door_open), 0);
    chk("t5_target6", int'(target_floor), 6);
    current_floor = 4'd6;
    tick();
    dwell_rest();
    current_floor = 4'd9;
    call(0);
    call(2);
    call(5);
    call(7);
    tick();
    chk("t6_pending", int'(pending), 'h0A5);
    chk("t6_target", int'(target_floor), 7);
    chk("t6_dir", int'(dir_up), 0);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_pending", int'(pending), 0);
    chk("t6_rst_target", int'(target_floor), 0);
    chk("t6_rst_dir", int'(dir_up), 1);
    chk("t6_rst_door", int'(door_open), 0);
    chk("t6_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    current_floor = 4'd15;
    call(3);
    tick();
    chk("t7_target", int'(target_floor), 3);
    chk("t7_dir", int'(dir_up), 0);
    current_floor = 4'd3;
    tick();
    dwell_rest();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Collects floor call requests, holds them in a pending-call bitmap, and picks the next target floor for the elevator state machine with a SCAN (keep-direction) policy. Its target_floor output drives the elevator FSM's requested_floor input. It reads back current_floor and the FSM's idle indication. It also times a door-open dwell at each served floor, and clears a call once that floor has been served.

Parameters:
NUM_FLOORS, 10, number of floors served (floors 0..NUM_FLOORS-1); at most 16.
DWELL_CYCLES, 32'd50000000, door-open dwell length in clk cycles; must be at least 1.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
call_valid  input  1  one-cycle call request strobe
call_floor  input  4  floor being requested; sampled when call_valid=1
current_floor  input  4  floor reported by the elevator FSM
car_idle  input  1  1 when the elevator FSM is in its IDLE state
target_floor  output  4  floor to drive into the elevator FSM's requested_floor
door_open  output  1  1 while dwelling at a served floor
dir_up  output  1  current/last sweep direction (1=up)
pending  output  NUM_FLOORS  registered pending-call bitmap
call_err  output  1  one-cycle pulse: call_floor >= NUM_FLOORS
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pending=0, target_floor=0, door_open=0, dir_up=1, dwell counter=0, call_err=0. The block leaves reset on the first clk edge after rst_n rises.
- Call capture: when call_valid=1 and call_floor<NUM_FLOORS, pending[call_floor] is set on the next edge (1-cycle latency).
  - If call_floor>=NUM_FLOORS, the call is ignored and call_err pulses high on the next cycle.
  - A call to an already-pending floor has no effect.
- Search signals, combinational from pending and current_floor:
  - above_any / below_any: any pending bit strictly above / below current_floor.
  - near_above: lowest pending floor > current_floor.
  - near_below: highest pending floor < current_floor.
- States: IDLE, SERVE_UP, SERVE_DOWN, DOOR.
- IDLE: target_floor=current_floor.
  - If pending[current_floor] and car_idle -> DOOR.
  - Else if both above_any and below_any: go SERVE_UP if dir_up=1, otherwise SERVE_DOWN.
  - Else if only above_any -> SERVE_UP (dir_up<=1).
  - Else if only below_any -> SERVE_DOWN (dir_up<=0).
- SERVE_UP: target_floor=near_above, re-evaluated every cycle, so a new call between the car and its target retargets to the nearer floor.
  - When pending[current_floor] and car_idle -> DOOR.
  - If above_any=0 and pending[current_floor]=0 -> IDLE.
- SERVE_DOWN: mirror of SERVE_UP, using near_below and below_any.
- DOOR:
  - On entry, pending[current_floor] is cleared, door_open=1, and the counter is loaded with 0.
  - target_floor is held at current_floor.
  - A call for current_floor during DOOR is absorbed: the bit is not set and the dwell is not restarted.
  - Calls for other floors are captured normally.
  - When the counter reaches DWELL_CYCLES-1: door_open drops on the next edge, and the block goes to the next serve state as follows.
    - If dir_up=1: go SERVE_UP if above_any, else SERVE_DOWN (dir_up<=0) if below_any, else IDLE.
    - If dir_up=0: the mirror rule.
- Simultaneous events: a new call set and a served-floor clear in the same cycle, on different floors, both take effect.
- car_idle=0 never opens the door; a pending current floor is only served once the car has stopped.
- Widths: the dwell counter is 32 bits. Floor compares are unsigned 4-bit. current_floor>=NUM_FLOORS is treated as having no pending bit at that floor.
- Reset mid-operation: everything returns to reset values immediately; pending calls are lost.

Decomposition:
- Shared package: state encoding constants (IDLE/SERVE_UP/SERVE_DOWN/DOOR), NUM_FLOORS default, floor width (4).
- One natural sub-module, call_priority_search: combinational; from pending and current_floor, produces above_any, below_any, near_above and near_below.
- The top block holds the FSM, the pending register, and the dwell counter.

Test Plan:
(All with DWELL_CYCLES=4, NUM_FLOORS=10.)
1. Reset, then call_floor=3 with current_floor=0, car_idle=1: pending=0x008 next cycle; state SERVE_UP; target_floor=3. Model current_floor reaching 3 with car_idle=1: door_open=1 for 4 cycles, pending=0, then IDLE, target_floor=3.
2. Car at 0 moving up to target 7, then call 4: target_floor switches to 4 the cycle after capture. Car stops at 4, DOOR, then resumes SERVE_UP with target_floor=7.
3. Car at 5, dir_up=1, calls 2 and 8 in the same window: 8 is served first, then dir_up=0 and target_floor=2.
4. call_floor=12: call_err pulses for 1 cycle; pending unchanged.
5. During DOOR at floor 4, call 4 again: pending[4] stays 0 and the dwell still ends after 4 cycles. A call to 6 in the same window sets pending[6].
6. Assert rst_n=0 during SERVE_DOWN with pending=0x0A5: all outputs are at reset values immediately, without waiting for a clock edge.
